// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - shared DB op/flag/state codes and issuer FSM encoding
package db_pkg;

    localparam logic SET_REQ = 1'b1;
    localparam logic GET_REQ = 1'b0;

    localparam int OP_RW_BIT   = 0;
    localparam int FLAG_ST_LSB = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_ARREST  = 2'b10,
        ST_EXPIRE  = 2'b11
    } db_state_e;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'b00,
        ISS_ISSUE = 2'b01,
        ISS_WAIT  = 2'b10
    } iss_state_e;

    function automatic logic flag_is_arrest(input logic [3:0] flag);
        return flag[FLAG_ST_LSB +: 2] == ST_ARREST;
    endfunction

endpackage

// File: rtl/db_key_fold.sv
// rtl/db_key_fold.sv - combinational 96-bit flow key to 32-bit XOR fold
module db_key_fold (
    input  logic [95:0] key_i,
    output logic [31:0] hash_o
);

    assign hash_o = key_i[95:64] ^ key_i[63:32] ^ key_i[31:0];

endmodule

// File: rtl/db_req_issuer.sv
// rtl/db_req_issuer.sv - one-at-a-time DB lookup initiator with fixed-latency verdict
module db_req_issuer
    import db_pkg::*;
#(
    parameter int HASH_SIZE  = 32,
    parameter int KEY_SIZE   = 96,
    parameter int VAL_SIZE   = 32,
    parameter int TXN_CYCLES = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [KEY_SIZE-1:0]  req_key,
    input  logic [VAL_SIZE-1:0]  req_value,
    output logic                 res_valid,
    output logic                 res_hit,
    output logic [3:0]           res_flag,
    output logic                 res_drop,
    output logic                 db_valid,
    output logic [3:0]           db_op,
    output logic [HASH_SIZE-1:0] db_hash,
    output logic [KEY_SIZE-1:0]  db_key,
    output logic [VAL_SIZE-1:0]  db_value,
    input  logic                 db_rsp_valid,
    input  logic [3:0]           db_rsp_flag,
    output logic [CNT_WIDTH-1:0] cnt_hit,
    output logic [CNT_WIDTH-1:0] cnt_miss
);

    localparam int WCW = $clog2(TXN_CYCLES);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(TXN_CYCLES - 2);

    iss_state_e           state_q, state_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 got_q, got_d;
    logic [3:0]           cap_q, cap_d;
    logic [3:0]           op_q, op_d;
    logic [HASH_SIZE-1:0] hash_q, hash_d;
    logic [KEY_SIZE-1:0]  key_q, key_d;
    logic [VAL_SIZE-1:0]  val_q, val_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_hit_q, res_hit_d;
    logic [3:0]           res_flag_q, res_flag_d;
    logic                 res_drop_q, res_drop_d;
    logic [CNT_WIDTH-1:0] cnt_hit_q, cnt_hit_d;
    logic [CNT_WIDTH-1:0] cnt_miss_q, cnt_miss_d;
    logic [31:0]          fold_w;

    db_key_fold u_fold (
        .key_i  (req_key),
        .hash_o (fold_w)
    );

    // The verdict cycle still blocks acceptance so transactions stay TXN_CYCLES+2 apart.
    assign req_ready = (state_q == ISS_IDLE) && !res_valid_q;
    assign db_valid  = (state_q == ISS_ISSUE);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        got_d       = got_q;
        cap_d       = cap_q;
        op_d        = op_q;
        hash_d      = hash_q;
        key_d       = key_q;
        val_d       = val_q;
        res_valid_d = 1'b0;
        res_hit_d   = res_hit_q;
        res_flag_d  = res_flag_q;
        res_drop_d  = res_drop_q;
        cnt_hit_d   = cnt_hit_q;
        cnt_miss_d  = cnt_miss_q;
        case (state_q)
            ISS_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    hash_d  = HASH_SIZE'(fold_w);
                    key_d   = req_key;
                    val_d   = req_value;
                    state_d = ISS_ISSUE;
                end
            end
            ISS_ISSUE: begin
                wcnt_d  = WAIT_LOAD;
                got_d   = 1'b0;
                cap_d   = 4'd0;
                state_d = ISS_WAIT;
            end
            ISS_WAIT: begin
                // Only the first strobe of a window counts; later ones are duplicates.
                if (db_rsp_valid && !got_q) begin
                    got_d = 1'b1;
                    cap_d = db_rsp_flag;
                end
                if (wcnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_hit_d   = got_d;
                    res_flag_d  = got_d ? cap_d : 4'd0;
                    res_drop_d  = got_d && flag_is_arrest(cap_d);
                    if (got_d) begin
                        if (cnt_hit_q != '1) cnt_hit_d = cnt_hit_q + 1'b1;
                    end else begin
                        if (cnt_miss_q != '1) cnt_miss_d = cnt_miss_q + 1'b1;
                    end
                    state_d = ISS_IDLE;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: state_d = ISS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ISS_IDLE;
            wcnt_q      <= '0;
            got_q       <= 1'b0;
            cap_q       <= 4'd0;
            op_q        <= 4'd0;
            hash_q      <= '0;
            key_q       <= '0;
            val_q       <= '0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_flag_q  <= 4'd0;
            res_drop_q  <= 1'b0;
            cnt_hit_q   <= '0;
            cnt_miss_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            got_q       <= got_d;
            cap_q       <= cap_d;
            op_q        <= op_d;
            hash_q      <= hash_d;
            key_q       <= key_d;
            val_q       <= val_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_flag_q  <= res_flag_d;
            res_drop_q  <= res_drop_d;
            cnt_hit_q   <= cnt_hit_d;
            cnt_miss_q  <= cnt_miss_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_hit   = res_hit_q;
    assign res_flag  = res_flag_q;
    assign res_drop  = res_drop_q;
    assign db_op     = op_q;
    assign db_hash   = hash_q;
    assign db_key    = key_q;
    assign db_value  = val_q;
    assign cnt_hit   = cnt_hit_q;
    assign cnt_miss  = cnt_miss_q;

endmodule
